// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types for the instruction-fetch sequencer
package fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        ADDR = 2'd0,
        DATA = 2'd1,
        HOLD = 2'd2,
        ADEL = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_reg.sv
// rtl/fetch_hold_reg.sv - word buffer that parks a fetched instruction while decode stalls
module fetch_hold_reg
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] d,
    output logic [31:0] q,
    output logic        valid
);

    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;

    // load wins over clear so a same-cycle handover never loses a word
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = d;
            valid_d = 1'b1;
        end else if (clear) begin
            data_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC owner and single-outstanding ibus sequencer
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output ibus_resp_t  f_resp,
    output logic [31:0] f_pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic         discard_q, discard_d;

    logic         hold_load, hold_clear, hold_valid;
    logic [31:0]  hold_data;
    logic         misaligned;
    logic         resp_phase;

    ibus_req_t    ireq_c;
    ibus_resp_t   f_resp_c;
    logic [31:0]  f_pc_c;

    fetch_hold_reg u_hold (
        .clk   (clk),
        .reset (reset),
        .load  (hold_load),
        .clear (hold_clear),
        .d     (iresp.data),
        .q     (hold_data),
        .valid (hold_valid)
    );

    assign misaligned = (pc_q[1:0] != 2'b00);

    // An accepted request (DATA, or ADDR with addr_ok this cycle) watches data_ok
    assign resp_phase = (state_q == DATA) ||
                        ((state_q == ADDR) && !misaligned && iresp.addr_ok);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        discard_d  = discard_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        ireq_c     = '0;
        f_resp_c   = '0;
        f_pc_c     = pc_q;

        case (state_q)
            ADDR, DATA: begin
                if (state_q == ADDR && misaligned) begin
                    // Synthesized AdEL word is presented in the same cycle
                    f_resp_c.data_ok = 1'b1;
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else begin
                        state_d = ADEL;
                    end
                end else begin
                    if (state_q == ADDR) begin
                        ireq_c.valid = 1'b1;
                        ireq_c.addr  = pc_q;
                    end
                    if (resp_phase && iresp.data_ok) begin
                        state_d   = ADDR;
                        discard_d = 1'b0;
                        if (discard_q || redirect_valid) begin
                            pc_d = redirect_valid ? redirect_pc : target_q;
                        end else if (!stall) begin
                            f_resp_c.data_ok = 1'b1;
                            f_resp_c.data    = iresp.data;
                            pc_d             = pc_q + 32'd4;
                        end else begin
                            hold_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end else begin
                        if (resp_phase) begin
                            state_d = DATA;
                        end
                        if (redirect_valid) begin
                            discard_d = 1'b1;
                            target_d  = redirect_pc;
                        end
                    end
                end
            end
            HOLD: begin
                f_resp_c.data_ok = hold_valid;
                f_resp_c.data    = hold_data;
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    hold_clear = 1'b1;
                    state_d    = ADDR;
                end else if (!stall) begin
                    pc_d       = pc_q + 32'd4;
                    hold_clear = 1'b1;
                    state_d    = ADDR;
                end
            end
            ADEL: begin
                f_resp_c.data_ok = 1'b1;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ADDR;
                end
            end
            default: begin
                state_d = ADDR;
            end
        endcase

        // Outputs are quiet while reset is held, regardless of bus activity
        if (reset) begin
            ireq_c.valid = 1'b0;
            f_resp_c     = '0;
            f_pc_c       = RESET_PC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ADDR;
            pc_q      <= RESET_PC;
            target_q  <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
            discard_q <= discard_d;
        end
    end

    assign ireq   = ireq_c;
    assign f_resp = f_resp_c;
    assign f_pc   = f_pc_c;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized checks of fetch_ctrl against a transaction model
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    ibus_resp_t  f_resp;
    logic [31:0] f_pc;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: what the fetch unit owes, in transaction terms
    logic [31:0] m_pc;
    logic        m_busy;
    logic        m_squash;
    logic [31:0] m_target;
    logic        m_have;
    logic [31:0] m_word;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .f_resp         (f_resp),
        .f_pc           (f_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic m_trapped();
        return !m_busy && !m_have && (m_pc % 4 != 0);
    endfunction

    function automatic logic m_requesting();
        return !m_busy && !m_have && (m_pc % 4 == 0);
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC_DEFAULT; m_busy = 0; m_squash = 0;
        m_target = RESET_PC_DEFAULT; m_have = 0; m_word = 0;
    endtask

    task automatic step(input logic rst_i, input logic aok, input logic dok,
                        input logic [31:0] data, input logic rv,
                        input logic [31:0] rpc, input logic st);
        logic       exp_valid, arrives, trapped, requesting;
        ibus_resp_t exp_f;
        @(negedge clk);
        reset = rst_i; iresp.addr_ok = aok; iresp.data_ok = dok; iresp.data = data;
        redirect_valid = rv; redirect_pc = rpc; stall = st;
        #1;
        if (rst_i) begin
            model_reset();
            chk("rst_ireq_valid", 64'(ireq.valid), 64'(0));
            chk("rst_f_resp", 64'(f_resp), 64'(0));
            chk("rst_f_pc", 64'(f_pc), 64'(RESET_PC_DEFAULT));
            return;
        end
        trapped    = m_trapped();
        requesting = m_requesting();
        exp_valid  = requesting;
        arrives    = (m_busy || (requesting && aok)) && dok;
        exp_f      = '0;
        if (trapped) exp_f.data_ok = 1;
        else if (m_have) begin exp_f.data_ok = 1; exp_f.data = m_word; end
        else if (arrives && !m_squash && !rv && !st) begin
            exp_f.data_ok = 1; exp_f.data = data;
        end
        chk("ireq_valid", 64'(ireq.valid), 64'(exp_valid));
        if (exp_valid) chk("ireq_addr", 64'(ireq.addr), 64'(m_pc));
        chk("f_resp", 64'(f_resp), 64'(exp_f));
        chk("f_pc", 64'(f_pc), 64'(m_pc));
        if (trapped) begin
            if (rv) m_pc = rpc;
        end else if (m_have) begin
            if (rv) begin m_pc = rpc; m_have = 0; end
            else if (!st) begin m_pc = m_pc + 4; m_have = 0; end
        end else if (arrives) begin
            m_busy = 0;
            if (m_squash || rv) begin m_pc = rv ? rpc : m_target; m_squash = 0; end
            else if (!st) m_pc = m_pc + 4;
            else begin m_have = 1; m_word = data; end
        end else begin
            if (requesting && aok) m_busy = 1;
            if (rv) begin m_squash = 1; m_target = rpc; end
        end
    endtask

    initial begin
        logic        aok, dok, rv, st;
        logic [31:0] rpc;
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h1234_5678, 1, 32'h8000_0000, 0);

        // Zero-stall fetch with same-cycle pass-through
        step(0, 1, 0, 0, 0, 0, 0);
        chk("tp1_addr", 64'(ireq.addr), 64'(32'hBFC0_0000));
        step(0, 0, 1, 32'h3C08_0001, 0, 0, 0);
        chk("tp1_data_ok", 64'(f_resp.data_ok), 64'(1));
        chk("tp1_data", 64'(f_resp.data), 64'(32'h3C08_0001));
        chk("tp1_pc", 64'(f_pc), 64'(32'hBFC0_0000));
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp1_next_addr", 64'(ireq.addr), 64'(32'hBFC0_0004));

        // Stall holds the word
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'hAAAA_5555, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("tp2_hold_data", 64'(f_resp.data), 64'(32'hAAAA_5555));
        chk("tp2_valid", 64'(ireq.valid), 64'(0));
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp2_last_pc", 64'(f_pc), 64'(32'hBFC0_0004));
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp2_next_addr", 64'(ireq.addr), 64'(32'hBFC0_0008));

        // Redirect in DATA drops the in-flight word
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h8000_0100, 0);
        step(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("tp3_dropped", 64'(f_resp.data_ok), 64'(0));
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp3_addr", 64'(ireq.addr), 64'(32'h8000_0100));

        // Redirect before addr_ok: request stays stable, then squashed
        step(0, 0, 0, 0, 1, 32'h8000_0200, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp4_stable", 64'(ireq.addr), 64'(32'h8000_0100));
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h1111_2222, 0, 0, 0);
        chk("tp4_dropped", 64'(f_resp.data_ok), 64'(0));
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp4_addr", 64'(ireq.addr), 64'(32'h8000_0200));

        // Misaligned target raises AdEL until redirected
        step(0, 0, 0, 0, 1, 32'h8000_0102, 0);
        step(0, 1, 1, 32'h3333_4444, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp5_valid", 64'(ireq.valid), 64'(0));
        chk("tp5_f", 64'(f_resp), 64'({1'b0, 1'b1, 32'h0}));
        chk("tp5_pc", 64'(f_pc), 64'(32'h8000_0102));
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 32'hBFC0_0380, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp5_resume", 64'(ireq.addr), 64'(32'hBFC0_0380));

        // Reset mid-transaction
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h5555_6666, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tp6_addr", 64'(ireq.addr), 64'(32'hBFC0_0000));

        // Randomized protocol-correct bus with redirects and stalls
        for (int i = 0; i < 3000; i++) begin
            aok = m_requesting() && ($urandom_range(0, 2) != 0);
            dok = (m_busy || aok) && ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFFC;
            st  = ($urandom_range(0, 2) == 0);
            step(0, aok, dok, $urandom, rv, rpc, st);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
